// File: rtl/vtg_pkg.sv
// vtg_pkg: shared pixel types, colour-bar palette and standard mode timings for video_timing_gen
package vtg_pkg;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_timing_t;
  localparam rgb_t BAR_COLORS [8] = '{
    rgb_t'(24'hFFFFFF), rgb_t'(24'hFFFF00), rgb_t'(24'h00FFFF), rgb_t'(24'h00FF00),
    rgb_t'(24'hFF00FF), rgb_t'(24'hFF0000), rgb_t'(24'h0000FF), rgb_t'(24'h000000)
  };
  localparam axis_timing_t MODE_1080P60_H = '{1920, 88, 44, 148};
  localparam axis_timing_t MODE_1080P60_V = '{1080, 4, 5, 36};
  localparam axis_timing_t MODE_720P60_H  = '{1280, 110, 40, 220};
  localparam axis_timing_t MODE_720P60_V  = '{720, 5, 5, 20};
  localparam axis_timing_t MODE_480P_H    = '{720, 16, 62, 60};
  localparam axis_timing_t MODE_480P_V    = '{480, 9, 6, 30};
endpackage

// File: rtl/vtg_axis.sv
// vtg_axis: one raster axis counter with active and sync region decode
module vtg_axis #(
  parameter int ACTIVE = 1920,
  parameter int FP = 88,
  parameter int SYNC = 44,
  parameter int BP = 148,
  localparam int TOTAL = ACTIVE + FP + SYNC + BP,
  localparam int W = $clog2(TOTAL)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         step_i,
  input  logic         clear_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o,
  output logic         active_o,
  output logic         sync_o
);
  logic [W-1:0] count_q, count_d;
  if (FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_params
    $error("vtg_axis: FP, SYNC and BP must each be at least 1");
  end
  always_comb begin
    wrap_o = step_i && count_q == W'(TOTAL - 1);
    count_d = (clear_i || wrap_o) ? '0 : step_i ? count_q + 1'b1 : count_q;
  end
  always_ff @(posedge clk_i) count_q <= rst_i ? '0 : count_d;
  assign count_o = count_q;
  assign active_o = count_q < W'(ACTIVE);
  assign sync_o = count_q >= W'(ACTIVE + FP) && count_q < W'(ACTIVE + FP + SYNC);
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: progressive raster sync/DE/coordinate source; define VTG_PATTERN_EN for colour bars on data_o
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP = 88,
  parameter int H_SYNC = 44,
  parameter int H_BP = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP = 4,
  parameter int V_SYNC = 5,
  parameter int V_BP = 36,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          run_i,
  output logic          hs_o,
  output logic          vs_o,
  output logic          de_o,
  output logic [HW-1:0] hc_o,
  output logic [VW-1:0] vc_o,
  output logic          sof_o,
  output logic [23:0]   data_o
);
  logic [HW-1:0] hc, hc_d, hc_q;
  logic [VW-1:0] vc, vc_d, vc_q;
  logic h_wrap, h_act, h_sync, v_act, v_sync, unused_v_wrap;
  logic hs_d, hs_q, vs_d, vs_q, de_d, de_q, sof_d, sof_q;
  logic [23:0] data_d, data_q;
  vtg_axis #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
    .clk_i(clk_i), .rst_i(rst_i), .step_i(run_i), .clear_i(~run_i),
    .count_o(hc), .wrap_o(h_wrap), .active_o(h_act), .sync_o(h_sync)
  );
  vtg_axis #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
    .clk_i(clk_i), .rst_i(rst_i), .step_i(h_wrap), .clear_i(~run_i),
    .count_o(vc), .wrap_o(unused_v_wrap), .active_o(v_act), .sync_o(v_sync)
  );
  always_comb begin
    de_d = run_i && h_act && v_act;
    hs_d = (run_i && h_sync) ? HS_POL : ~HS_POL;
    vs_d = (run_i && v_sync) ? VS_POL : ~VS_POL;
    sof_d = run_i && hc == '0 && vc == '0;
    hc_d = run_i ? hc : '0;
    vc_d = run_i ? vc : '0;
  end
`ifdef VTG_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic [2:0] bar_q, bar_d;
  logic [HW-1:0] bar_cnt_q, bar_cnt_d;
  logic bar_end;
  // bar index tracks hc in lockstep; the last bar never advances so it absorbs the remainder
  always_comb begin
    bar_end = bar_cnt_q == HW'(BAR_W - 1) && bar_q != 3'd7;
    bar_d = (!run_i || h_wrap) ? '0 : bar_end ? bar_q + 1'b1 : bar_q;
    bar_cnt_d = (!run_i || h_wrap || bar_end) ? '0 : bar_cnt_q + 1'b1;
    data_d = de_d ? BAR_COLORS[bar_q] : '0;
  end
  always_ff @(posedge clk_i) begin
    bar_q <= rst_i ? '0 : bar_d;
    bar_cnt_q <= rst_i ? '0 : bar_cnt_d;
  end
`else
  assign data_d = '0;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      de_q <= 1'b0;
      sof_q <= 1'b0;
      hc_q <= '0;
      vc_q <= '0;
      data_q <= '0;
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      sof_q <= sof_d;
      hc_q <= hc_d;
      vc_q <= vc_d;
      data_q <= data_d;
    end
  end
  assign hs_o = hs_q;
  assign vs_o = vs_q;
  assign de_o = de_q;
  assign sof_o = sof_q;
  assign hc_o = hc_q;
  assign vc_o = vc_q;
  assign data_o = data_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench for video_timing_gen in a 24x8 raster, both sync polarities
module tb_video_timing_gen;
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic sof;
    logic [4:0] hc;
    logic [2:0] vc;
    logic [23:0] data;
  } vo_t;
  logic clk = 1'b0, rst_i = 1'b1, run_i = 1'b0;
  logic hs0, vs0, de0, sof0, hs1, vs1, de1, sof1;
  logic [4:0] hc0, hc1;
  logic [2:0] vc0, vc1;
  logic [23:0] data0, data1;
  int pass_cnt = 0, total_cnt = 0, mh = 0, mv = 0;
  vo_t q[$];
  vo_t e, obs;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  always #5 clk = ~clk;
  video_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .run_i(run_i), .hs_o(hs0), .vs_o(vs0), .de_o(de0),
    .hc_o(hc0), .vc_o(vc0), .sof_o(sof0), .data_o(data0)
  );
  video_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .HS_POL(1'b0), .VS_POL(1'b0)) dut_neg (
    .clk_i(clk), .rst_i(rst_i), .run_i(run_i), .hs_o(hs1), .vs_o(vs1), .de_o(de1),
    .hc_o(hc1), .vc_o(vc1), .sof_o(sof1), .data_o(data1)
  );
  function automatic vo_t obs0();
    return {hs0, vs0, de0, sof0, hc0, vc0, data0};
  endfunction
  function automatic vo_t obs1();
    return {~hs1, ~vs1, de1, sof1, hc1, vc1, data1};
  endfunction
  // model: expected registered outputs for the coming edge, then advance the model raster
  task automatic cycle(input logic r, input logic rn);
    vo_t x;
    rst_i = r;
    run_i = rn;
    x = '0;
    if (!r && rn) begin
      x.hs = mh >= 18 && mh < 21;
      x.vs = mv >= 5 && mv < 7;
      x.de = mh < 16 && mv < 4;
      x.sof = mh == 0 && mv == 0;
      x.hc = 5'(mh);
      x.vc = 3'(mv);
`ifdef VTG_PATTERN_EN
      x.data = x.de ? bars[mh / 2] : 24'h0;
`endif
      mh = (mh + 1) % 24;
      if (mh == 0) mv = (mv + 1) % 8;
    end else begin
      mh = 0;
      mv = 0;
    end
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1);
      e = q.pop_front(); obs = obs0(); total_cnt++;
      if (obs !== e) $display("FAIL reset_state got %h want %h", obs, e); else pass_cnt++;
    end
    cycle(1'b0, 1'b1);
    e = q.pop_front(); obs = obs0(); total_cnt++;
    if (obs !== e) $display("FAIL first_pixel got %h want %h", obs, e); else pass_cnt++;
    total_cnt++;
    if ({de0, sof0, hc0, vc0} !== {1'b1, 1'b1, 5'd0, 3'd0})
      $display("FAIL first_pixel_fields got de=%b sof=%b hc=%0d vc=%0d want 1 1 0 0", de0, sof0, hc0, vc0);
    else pass_cnt++;
  endtask
  task automatic test_frame_timing();
    int de_n = 0, vs_n = 0, vs_bad = 0, hs_n = 0, hs_bad = 0, de_in_vs = 0, falls = 0, run_bad = 0, run_len = 1, sof_at = -1;
    logic prev = 1'b1;
    for (int k = 1; k <= 192; k++) begin
      cycle(1'b0, 1'b1);
      e = q.pop_front(); obs = obs0(); total_cnt++;
      if (obs !== e) $display("FAIL frame_cycle_%0d got %h want %h", k, obs, e); else pass_cnt++;
      if (de0) begin de_n++; run_len++; end
      if (vs0) begin vs_n++; if (vc0 < 5 || vc0 > 6) vs_bad++; if (de0) de_in_vs++; end
      if (hs0) begin hs_n++; if (hc0 < 18 || hc0 > 20) hs_bad++; end
      if (prev && !de0) begin falls++; if (run_len != 16) run_bad++; end
      if (!prev && de0) run_len = 1;
      if (sof0 && sof_at < 0) sof_at = k;
      prev = de0;
    end
    total_cnt++; if (de_n !== 64) $display("FAIL de_per_frame got %0d want 64", de_n); else pass_cnt++;
    total_cnt++; if (run_bad !== 0) $display("FAIL de_run_16 got %0d bad runs want 0", run_bad); else pass_cnt++;
    total_cnt++; if (hs_n !== 24) $display("FAIL hs_cycles got %0d want 24", hs_n); else pass_cnt++;
    total_cnt++; if (hs_bad !== 0) $display("FAIL hs_position got %0d stray want 0", hs_bad); else pass_cnt++;
    total_cnt++; if (vs_n !== 48) $display("FAIL vs_cycles got %0d want 48", vs_n); else pass_cnt++;
    total_cnt++; if (vs_bad !== 0) $display("FAIL vs_lines got %0d stray want 0", vs_bad); else pass_cnt++;
    total_cnt++; if (de_in_vs !== 0) $display("FAIL de_during_vs got %0d want 0", de_in_vs); else pass_cnt++;
    total_cnt++; if (falls !== 4) $display("FAIL de_falls got %0d want 4", falls); else pass_cnt++;
    total_cnt++; if (sof_at !== 192) $display("FAIL sof_period got %0d want 192", sof_at); else pass_cnt++;
  endtask
  task automatic test_polarity();
    cycle(1'b1, 1'b1);
    e = q.pop_front(); total_cnt++;
    if ({hs1, vs1} !== 2'b11) $display("FAIL neg_reset_sync got %b%b want 11", hs1, vs1); else pass_cnt++;
    for (int k = 0; k < 192; k++) begin
      cycle(1'b0, 1'b1);
      e = q.pop_front(); obs = obs1(); total_cnt++;
      if (obs !== e) $display("FAIL neg_pol_cycle_%0d got %h want %h", k, obs, e); else pass_cnt++;
    end
  endtask
  task automatic test_run_and_reset();
    bit found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      cycle(1'b0, 1'b1);
      e = q.pop_front(); obs = obs0(); total_cnt++;
      if (obs !== e) $display("FAIL seek_cycle_%0d got %h want %h", k, obs, e); else pass_cnt++;
      found = vc0 == 3'd2 && hc0 == 5'd7;
    end
    total_cnt++;
    if (!found) $display("FAIL seek_v2_h7 got timeout want position reached"); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0);
      e = q.pop_front(); obs = obs0(); total_cnt++;
      if (obs !== e || obs !== '0) $display("FAIL run_low_idle got %h want %h", obs, e); else pass_cnt++;
      total_cnt++;
      if ({hs1, vs1, de1} !== 3'b110) $display("FAIL run_low_neg got %b%b%b want 110", hs1, vs1, de1); else pass_cnt++;
    end
    cycle(1'b0, 1'b1);
    e = q.pop_front(); obs = obs0(); total_cnt++;
    if (obs !== e || sof0 !== 1'b1) $display("FAIL run_restart got %h want %h", obs, e); else pass_cnt++;
    for (int k = 0; k < 30; k++) begin
      cycle(1'b0, 1'b1);
      e = q.pop_front(); obs = obs0(); total_cnt++;
      if (obs !== e) $display("FAIL after_restart_%0d got %h want %h", k, obs, e); else pass_cnt++;
    end
    cycle(1'b1, 1'b1);
    e = q.pop_front(); obs = obs0(); total_cnt++;
    if (obs !== e || obs !== '0) $display("FAIL midline_reset got %h want %h", obs, e); else pass_cnt++;
    cycle(1'b0, 1'b1);
    e = q.pop_front(); obs = obs0(); total_cnt++;
    if (obs !== e || sof0 !== 1'b1) $display("FAIL after_reset_sof got %h want %h", obs, e); else pass_cnt++;
  endtask
  task automatic test_pattern();
    for (int k = 0; k < 192; k++) begin
      cycle(1'b0, 1'b1);
      e = q.pop_front(); obs = obs0(); total_cnt++;
      if (obs !== e) $display("FAIL pattern_cycle_%0d got %h want %h", k, obs, e); else pass_cnt++;
`ifdef VTG_PATTERN_EN
      if (de0 && hc0 == 5'd1) begin
        total_cnt++; if (data0 !== 24'hFFFFFF) $display("FAIL bar_white got %h want ffffff", data0); else pass_cnt++;
      end
      if (de0 && hc0 == 5'd3) begin
        total_cnt++; if (data0 !== 24'hFFFF00) $display("FAIL bar_yellow got %h want ffff00", data0); else pass_cnt++;
      end
      if (de0 && hc0 == 5'd14) begin
        total_cnt++; if (data0 !== 24'h000000) $display("FAIL bar_black got %h want 000000", data0); else pass_cnt++;
      end
      if (!de0) begin
        total_cnt++; if (data0 !== 24'h0) $display("FAIL blank_data got %h want 0", data0); else pass_cnt++;
      end
`else
      total_cnt++; if (data0 !== 24'h0) $display("FAIL data_tied got %h want 0", data0); else pass_cnt++;
`endif
    end
  endtask
  initial begin
    test_reset();
    test_frame_timing();
    test_polarity();
    test_run_and_reset();
    test_pattern();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
